// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports, the memory port and the arbiter status.
// slave: the arbiter's view. master: the environment (caches + RAM model).
// Pure wiring; no state and no latency of its own.
interface mem_port_arbiter_if #(
    parameter int XLEN = 32
);
    logic            req0;
    logic            we0;
    logic [XLEN-1:0] addr0;
    logic [XLEN-1:0] wdata0;
    logic [XLEN-1:0] rdata0;
    logic            ack0;

    logic            req1;
    logic            we1;
    logic [XLEN-1:0] addr1;
    logic [XLEN-1:0] wdata1;
    logic [XLEN-1:0] rdata1;
    logic            ack1;

    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wd;
    logic [XLEN-1:0] mem_rd;
    logic            mem_ready;

    logic            busy;
    logic            gnt;
    logic            err;

    modport slave (
        input  req0, we0, addr0, wdata0,
        output rdata0, ack0,
        input  req1, we1, addr1, wdata1,
        output rdata1, ack1,
        output mem_req, mem_we, mem_addr, mem_wd,
        input  mem_rd, mem_ready,
        output busy, gnt, err
    );

    modport master (
        output req0, we0, addr0, wdata0,
        input  rdata0, ack0,
        output req1, we1, addr1, wdata1,
        input  rdata1, ack1,
        input  mem_req, mem_we, mem_addr, mem_wd,
        output mem_rd, mem_ready,
        input  busy, gnt, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the data cache (0) and instruction fetch (1).
// Latency: req -> mem_req next cycle; mem_ready -> ack one cycle later; one idle cycle between grants.
// Backpressure: requesters hold req until ack; memory stalls freely via mem_ready.
// Optional MEM_ARB_RR_EN: round-robin between requesters instead of fixed priority to requester 0.
module mem_port_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64
) (
    input logic             clk,
    input logic             rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int              CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]   TMAX      = CW'(TIMEOUT);
    localparam logic [XLEN-1:0] ADDR_MASK = ~XLEN'(3);

    state_t          state;
    state_t          state_nxt;
    logic            any_req;
    logic            win;
    logic [CW-1:0]   wait_cnt;
    logic [CW-1:0]   wait_inc;
    logic            lat_we;
    logic [XLEN-1:0] lat_addr;
    logic [XLEN-1:0] lat_wd;
    logic            gnt_q;
    logic            ack0_q;
    logic            ack1_q;
    logic            err_q;
    logic [XLEN-1:0] rdata0_q;
    logic [XLEN-1:0] rdata1_q;

    assign any_req  = bus.req0 | bus.req1;
    assign wait_inc = wait_cnt + 1'b1;

`ifdef MEM_ARB_RR_EN
    logic ptr;

    // Pointer names the requester that wins a tie; it moves on after each completed grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (state == DONE) begin
            ptr <= ~ptr;
        end
    end

    // Tie goes to the pointer; a lone requester always wins.
    always_comb begin
        win = 1'b0;
        if (bus.req0 && bus.req1) begin
            win = ptr;
        end else begin
            win = ~bus.req0;
        end
    end
`else
    // Requester 0 wins whenever it asks.
    always_comb begin
        win = ~bus.req0;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: grant from IDLE, wait for mem_ready in BUSY, single-cycle DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = BUSY;
            BUSY:    if (bus.mem_ready) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Transaction latch, read-data capture, ack pulses and watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_we   <= 1'b0;
            lat_addr <= '0;
            lat_wd   <= '0;
            gnt_q    <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        lat_we   <= win ? bus.we1 : bus.we0;
                        lat_addr <= (win ? bus.addr1 : bus.addr0) & ADDR_MASK;
                        lat_wd   <= win ? bus.wdata1 : bus.wdata0;
                        gnt_q    <= win;
                        wait_cnt <= '0;
                    end
                end
                BUSY: begin
                    // Saturates at TIMEOUT; with TIMEOUT=0 it never moves, so err never sets.
                    if (wait_cnt != TMAX) begin
                        wait_cnt <= wait_inc;
                        if (wait_inc == TMAX) err_q <= 1'b1;
                    end
                    if (bus.mem_ready) begin
                        if (!lat_we) begin
                            if (gnt_q) rdata1_q <= bus.mem_rd;
                            else       rdata0_q <= bus.mem_rd;
                        end
                        ack0_q <= ~gnt_q;
                        ack1_q <= gnt_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Every output comes straight from a flop (mem_req/busy decode the state register).
    assign bus.mem_req  = (state == BUSY);
    assign bus.busy     = (state != IDLE);
    assign bus.mem_we   = lat_we;
    assign bus.mem_addr = lat_addr;
    assign bus.mem_wd   = lat_wd;
    assign bus.gnt      = gnt_q;
    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.err      = err_q;
    assign bus.rdata0   = rdata0_q;
    assign bus.rdata1   = rdata1_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, reads, writes, contention, watchdog, dropped request.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
// Expected grant order follows MEM_ARB_RR_EN when the bench is built with it.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   n_ack0;
    int   n_ack1;
    int   n_both;

    mem_port_arbiter_if #(.XLEN(32)) bus ();

    mem_port_arbiter #(.XLEN(32), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tally ack pulses and any cycle where both acks are high.
    always @(negedge clk) begin
        if (bus.ack0) n_ack0++;
        if (bus.ack1) n_ack1++;
        if (bus.ack0 && bus.ack1) n_both++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.ack0, bus.ack1, bus.busy, bus.gnt, bus.err} !== 7'b0) begin
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {bus.mem_req, bus.mem_we, bus.ack0, bus.ack1, bus.busy, bus.gnt, bus.err});
            errors++;
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wd} !== 64'h0) begin
            $display("FAIL reset_mem_bus: got %h %h expected 0", bus.mem_addr, bus.mem_wd);
            errors++;
        end
        checks++;
        if ({bus.rdata0, bus.rdata1} !== 64'h0) begin
            $display("FAIL reset_rdata: got %h %h expected 0", bus.rdata0, bus.rdata1);
            errors++;
        end
    endtask

    task automatic test_single_read();
        int a1;
        a1 = n_ack1;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h0000_1006;
        tick();
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.gnt, bus.busy} !== 4'b1001) begin
            $display("FAIL read_issue: got req/we/gnt/busy=%b expected 1001",
                     {bus.mem_req, bus.mem_we, bus.gnt, bus.busy});
            errors++;
        end
        checks++;
        if (bus.mem_addr !== 32'h0000_1004) begin
            $display("FAIL read_addr_aligned: got %h expected 00001004", bus.mem_addr);
            errors++;
        end
        tick();
        tick();
        bus.mem_ready = 1'b1; bus.mem_rd = 32'hDEAD_BEEF;
        tick();
        bus.mem_ready = 1'b0; bus.req0 = 1'b0;
        checks++;
        if ({bus.ack0, bus.ack1, bus.mem_req} !== 3'b100 || bus.rdata0 !== 32'hDEAD_BEEF) begin
            $display("FAIL read_ack: got ack0/ack1/mem_req=%b rdata0=%h expected 100 deadbeef",
                     {bus.ack0, bus.ack1, bus.mem_req}, bus.rdata0);
            errors++;
        end
        tick();
        tick();
        checks++;
        if ({bus.ack0, bus.busy} !== 2'b00 || n_ack1 != a1) begin
            $display("FAIL read_after: got ack0/busy=%b ack1 pulses=%0d expected 00 and 0",
                     {bus.ack0, bus.busy}, n_ack1 - a1);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h0000_2000; bus.wdata0 = 32'h1234_5678;
        tick();
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_wd !== 32'h1234_5678 || bus.mem_addr !== 32'h0000_2000) begin
            $display("FAIL wb_issue: got we=%b wd=%h addr=%h expected 1 12345678 00002000",
                     bus.mem_we, bus.mem_wd, bus.mem_addr);
            errors++;
        end
        bus.mem_ready = 1'b1; bus.mem_rd = 32'h9999_9999;
        tick();
        bus.mem_ready = 1'b0; bus.we0 = 1'b0; bus.addr0 = 32'h0000_4000;
        checks++;
        if (bus.ack0 !== 1'b1 || bus.rdata0 !== 32'hDEAD_BEEF) begin
            $display("FAIL wb_ack: got ack0=%b rdata0=%h expected 1 deadbeef", bus.ack0, bus.rdata0);
            errors++;
        end
        tick();
        checks++;
        if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin
            $display("FAIL refill_gap: got mem_req=%b busy=%b expected 0 0", bus.mem_req, bus.busy);
            errors++;
        end
        tick();
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0000_4000) begin
            $display("FAIL refill_issue: got req=%b we=%b addr=%h expected 1 0 00004000",
                     bus.mem_req, bus.mem_we, bus.mem_addr);
            errors++;
        end
        bus.mem_ready = 1'b1; bus.mem_rd = 32'hCAFE_F00D;
        tick();
        bus.mem_ready = 1'b0; bus.req0 = 1'b0;
        checks++;
        if (bus.ack0 !== 1'b1 || bus.rdata0 !== 32'hCAFE_F00D) begin
            $display("FAIL refill_ack: got ack0=%b rdata0=%h expected 1 cafef00d", bus.ack0, bus.rdata0);
            errors++;
        end
        tick();
    endtask

    task automatic test_contention();
        logic       exp_g [5];
        logic [31:0] exp_rd0;
        logic [31:0] exp_rd1;
`ifdef MEM_ARB_RR_EN
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`else
        exp_g = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
        apply_reset();
        exp_rd0 = 32'h0; exp_rd1 = 32'h0;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h0000_0100;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h0000_0200;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) bus.req0 = 1'b0;
            tick();
            checks++;
            if (bus.gnt !== exp_g[i] || bus.mem_addr !== (exp_g[i] ? 32'h200 : 32'h100)) begin
                $display("FAIL cont_gnt[%0d]: got gnt=%b addr=%h expected %b", i, bus.gnt, bus.mem_addr, exp_g[i]);
                errors++;
            end
            bus.mem_ready = 1'b1; bus.mem_rd = 32'hA000_0000 + i;
            if (exp_g[i]) exp_rd1 = 32'hA000_0000 + i;
            else          exp_rd0 = 32'hA000_0000 + i;
            tick();
            bus.mem_ready = 1'b0;
            if (i == 4) bus.req1 = 1'b0;
            checks++;
            if (bus.ack0 !== ~exp_g[i] || bus.ack1 !== exp_g[i] ||
                bus.rdata0 !== exp_rd0 || bus.rdata1 !== exp_rd1) begin
                $display("FAIL cont_ack[%0d]: got ack0=%b ack1=%b rd0=%h rd1=%h expected rd0=%h rd1=%h",
                         i, bus.ack0, bus.ack1, bus.rdata0, bus.rdata1, exp_rd0, exp_rd1);
                errors++;
            end
            tick();
        end
    endtask

    task automatic test_watchdog_reset();
        int a0;
        apply_reset();
        a0 = n_ack0;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h0000_0300;
        tick();
        for (int k = 0; k < 7; k++) tick();
        checks++;
        if (bus.err !== 1'b0) begin
            $display("FAIL wd_early: got err=%b expected 0 after 7 busy cycles", bus.err);
            errors++;
        end
        tick();
        checks++;
        if (bus.err !== 1'b1 || bus.mem_req !== 1'b1) begin
            $display("FAIL wd_set: got err=%b mem_req=%b expected 1 1", bus.err, bus.mem_req);
            errors++;
        end
        tick();
        tick();
        checks++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b1) begin
            $display("FAIL wd_sticky: got err=%b busy=%b expected 1 1", bus.err, bus.busy);
            errors++;
        end
        rst = 1'b1; bus.req0 = 1'b0;
        tick();
        rst = 1'b0;
        checks++;
        if ({bus.mem_req, bus.ack0, bus.ack1, bus.busy, bus.gnt, bus.err} !== 6'b0 || bus.mem_addr !== 32'h0) begin
            $display("FAIL wd_reset: got ctrl=%b addr=%h expected 000000 0",
                     {bus.mem_req, bus.ack0, bus.ack1, bus.busy, bus.gnt, bus.err}, bus.mem_addr);
            errors++;
        end
        tick();
        checks++;
        if (n_ack0 != a0 || bus.busy !== 1'b0) begin
            $display("FAIL wd_no_ack: got ack0 pulses=%0d busy=%b expected 0 0", n_ack0 - a0, bus.busy);
            errors++;
        end
    endtask

    task automatic test_dropped_request();
        int a0;
        int a1;
        a0 = n_ack0; a1 = n_ack1;
        bus.mem_ready = 1'b1; bus.mem_rd = 32'h1111_1111;
        tick();
        bus.mem_ready = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.rdata1 !== 32'h0) begin
            $display("FAIL idle_ready_ignored: got busy=%b rdata1=%h expected 0 0", bus.busy, bus.rdata1);
            errors++;
        end
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h0000_0500;
        tick();
        bus.req1 = 1'b0; bus.addr1 = 32'h0000_0999;
        tick();
        checks++;
        if (bus.gnt !== 1'b1 || bus.mem_addr !== 32'h0000_0500 || bus.mem_req !== 1'b1) begin
            $display("FAIL drop_latched: got gnt=%b addr=%h req=%b expected 1 00000500 1",
                     bus.gnt, bus.mem_addr, bus.mem_req);
            errors++;
        end
        bus.mem_ready = 1'b1; bus.mem_rd = 32'h0000_55AA;
        tick();
        bus.mem_ready = 1'b0;
        checks++;
        if (bus.ack1 !== 1'b1 || bus.rdata1 !== 32'h0000_55AA) begin
            $display("FAIL drop_ack: got ack1=%b rdata1=%h expected 1 000055aa", bus.ack1, bus.rdata1);
            errors++;
        end
        tick();
        tick();
        tick();
        checks++;
        if (n_ack1 - a1 != 1 || n_ack0 != a0 || bus.busy !== 1'b0) begin
            $display("FAIL drop_once: got ack1 pulses=%0d ack0 pulses=%0d busy=%b expected 1 0 0",
                     n_ack1 - a1, n_ack0 - a0, bus.busy);
            errors++;
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        n_ack0 = 0; n_ack1 = 0; n_both = 0;
        rst = 1'b1;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        bus.mem_rd = '0; bus.mem_ready = 1'b0;
        #1;
        test_reset();
        test_single_read();
        test_back_to_back();
        test_contention();
        test_watchdog_reset();
        test_dropped_request();
        checks++;
        if (n_both != 0) begin
            $display("FAIL ack_exclusive: got %0d overlapping cycles expected 0", n_both);
            errors++;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between the data cache (requester 0: line refills and dirty write-backs) and the instruction fetch path (requester 1).
- Each granted request becomes one memory transaction. The memory may take any number of cycles and finishes with mem_ready. The arbiter returns read data with a one-cycle ack pulse.
- Sits between the caches and the RAM model in the superscalar core. Cache stall logic holds its request stable until the ack arrives.

Parameters:
- XLEN, 32, address/data width.
- TIMEOUT, 64, cycles in BUSY without mem_ready before the sticky error flag sets; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req0  in  1  data-cache request; held high until ack0
- we0  in  1  request 0 is a write
- addr0  in  XLEN  request 0 word address; bits [1:0] ignored
- wdata0  in  XLEN  request 0 write data
- rdata0  out  XLEN  read data for request 0; valid while ack0=1
- ack0  out  1  one-cycle completion pulse for request 0
- req1, we1, addr1, wdata1, rdata1, ack1  same widths and meanings, for the instruction path
- mem_req  out  1  memory transaction active
- mem_we  out  1  write transaction
- mem_addr  out  XLEN  word-aligned address, {addr[XLEN-1:2],2'b00}
- mem_wd  out  XLEN  write data
- mem_rd  in  XLEN  memory read data; valid when mem_ready=1
- mem_ready  in  1  transaction complete this cycle
- busy  out  1  state != IDLE
- gnt  out  1  index of the current or last granted requester
- err  out  1  sticky watchdog timeout flag

Behaviour:
- Reset values: all outputs 0, state IDLE, wait counter 0, priority pointer 0. Reset mid-transaction abandons it with no ack.
- All outputs are registered. Nothing combinational runs from any input to any output.
- State IDLE:
  - If any req is high, pick a winner per the arbitration rule.
  - Latch the winner's we, addr, wdata and index.
  - Next cycle: state BUSY, mem_req=1 with the latched fields, gnt=index.
- State BUSY:
  - mem_req and the latched fields stay constant. The requester's live inputs are not re-sampled.
  - Wait counter increments each cycle.
  - When mem_ready=1 is sampled: capture mem_rd into the winner's rdata register (writes capture nothing; rdata keeps its old value). Next cycle: mem_req=0, ackN=1 for the winner only, state DONE.
  - mem_ready while in IDLE or DONE is ignored.
- State DONE:
  - Lasts one cycle; ack deasserts and state returns to IDLE.
  - Requests are not sampled in DONE. A requester that keeps req high after its ack re-enters arbitration in the following IDLE cycle.
- Minimum latency: req at cycle 0 -> mem_req at cycle 1 -> mem_ready at cycle 1 -> ack at cycle 2. The next grant's mem_req appears at cycle 4 at the earliest.
- Arbitration rule (default, fixed priority): requester 0 wins whenever req0=1.
- Dropped request: if the requester drops req before its ack, the latched transaction still completes and the ack still pulses.
- Watchdog:
  - If TIMEOUT>0 and the wait counter reaches TIMEOUT in BUSY, err sets and stays set until rst.
  - The transaction keeps waiting; no abort.
  - The counter saturates and clears on entering BUSY.
- ack0 and ack1 are never high together. mem_req is never high in IDLE.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - The priority pointer flips to the other requester after every completed grant (at DONE).
  - When both req are high in IDLE, the pointer's requester wins. A single requester always wins.
- Undefined: fixed priority to requester 0; the pointer register is absent.

Test Plan:
- Single read: req0=1, addr0=0x0000_1004, memory answers mem_ready 3 cycles after mem_req with mem_rd=0xDEADBEEF -> mem_addr=0x0000_1004, mem_we=0; ack0 one cycle later with rdata0=0xDEADBEEF; ack1 never set.
- Write-back, then refill on the same requester: req0 write to 0x2000 with 0x1234_5678, then read from 0x4000 held high through the ack -> first mem_we=1 and mem_wd=0x12345678; a second mem_req with mem_we=0 begins exactly 2 cycles after ack0.
- Contention, macro undefined: req0 and req1 both high, each completing a grant with 1-cycle memory latency -> grants 0,0,0; ack1 never set until req0 drops.
- Contention, MEM_ARB_RR_EN defined: same stimulus -> grants alternate 0,1,0,1; each ack reaches the correct requester with the matching rdata.
- Reset and watchdog: TIMEOUT=8, mem_ready held low -> err=1 after 8 BUSY cycles, mem_req still 1. Then assert rst for 1 cycle -> all outputs 0, state IDLE, no ack emitted.
- Dropped request: req1 asserted for 1 cycle only, mem_ready after 2 cycles -> ack1 still pulses once; mem_addr is the value latched at grant even though addr1 changed.
